// File: rtl/pistorm_pkg.sv
// -----------------------------------------------------------------------------
// pistorm_pkg
// Shared definitions for the PiStorm bus interface blocks.
//   - Arbiter state encoding and the width of the arb_state status field.
//   - Pi-side register map constants (register addresses and status bits).
//   - Small decode helpers mapping an arbiter state to the bus pins it drives.
// -----------------------------------------------------------------------------
package pistorm_pkg;

    // Width of the arbiter state field exported to the Pi status register.
    localparam int ARB_STATE_W = 3;

    // Arbiter states. Code 3'd7 is unused and recovers to ARB_IDLE.
    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQ       = 3'd1,
        ARB_WAIT_FREE = 3'd2,
        ARB_ACK       = 3'd3,
        ARB_OWN       = 3'd4,
        ARB_REL       = 3'd5,
        ARB_HOLDOFF   = 3'd6
    } arb_state_e;

    // Pi register map (register select on the Pi side of the bridge).
    localparam logic [2:0] PI_REG_DATA_LO  = 3'd0;
    localparam logic [2:0] PI_REG_DATA_HI  = 3'd1;
    localparam logic [2:0] PI_REG_ADDR_LO  = 3'd2;
    localparam logic [2:0] PI_REG_ADDR_HI  = 3'd3;
    localparam logic [2:0] PI_REG_STATUS   = 3'd4;
    localparam logic [2:0] PI_REG_CONTROL  = 3'd5;

    // Status register bit positions.
    localparam int PI_STATUS_ARB_LSB   = 0;
    localparam int PI_STATUS_OWNED     = 3;
    localparam int PI_STATUS_TIMEOUT   = 4;

    // Control register bit positions.
    localparam int PI_CONTROL_ACQ_REQ  = 0;

    // nBR is asserted while asking for the bus and until ownership is taken.
    function automatic logic arb_drives_br(input arb_state_e s);
        return (s == ARB_REQ) || (s == ARB_WAIT_FREE) || (s == ARB_ACK);
    endfunction

    // nBGACK is asserted from acknowledge until the bus is handed back.
    function automatic logic arb_drives_bgack(input arb_state_e s);
        return (s == ARB_ACK) || (s == ARB_OWN) || (s == ARB_REL);
    endfunction

    // The access engine may only start cycles while the bus is owned.
    function automatic logic arb_is_owned(input arb_state_e s);
        return (s == ARB_OWN);
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// arb_timeout_cnt
// Saturating event counter used by the bus arbiter to bound how many 68k
// clock falling edges it waits for a grant or for the bus to go quiet.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset, clears the count
//   clear    in   synchronous clear of the count
//   enable   in   count one event this cycle
//   expired  out  the count after the current event reaches LIMIT
//                 (combinational look-ahead, valid regardless of enable)
// -----------------------------------------------------------------------------
module arb_timeout_cnt #(
    parameter int          CNT_W = 16,
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;

    // Saturating increment and look-ahead limit comparison.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
        // Compare at 32 bits so LIMIT may exceed the counter range: a
        // saturated counter below LIMIT never expires.
        expired = (32'(cnt_inc_s) >= 32'(LIMIT));
    end

    // Next count: clear wins over counting.
    always_comb begin
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// bus_arbiter_ctrl
// 68000 bus-master arbitration for the PiStorm bridge. Requests the bus with
// nBR, waits for nBG and a quiet bus, takes it with nBGACK, and hands it back
// once the Pi drops its request and the access engine is idle. Gives up with
// a timeout pulse when the grant or quiescence takes too many 68k clocks.
// Ports:
//   sys_clk                   in   sole clock, rising edge
//   reset                     in   synchronous active-high reset
//   mc_clk_rising/_falling    in   one-cycle strobes at 68k clock edges
//   acq_req                   in   Pi request for bus mastership (level)
//   bg_n_sync, as_n_sync,
//   dtack_n_sync, bgack_n_sync,
//   reset_n_sync              in   synchronized active-low 68k bus inputs
//   eng_busy                  in   access engine is mid-cycle
//   br_drive                  out  drive nBR low
//   bgack_drive               out  drive nBGACK low
//   owned                     out  access engine may start cycles
//   timeout                   out  one-cycle pulse on arbitration timeout
//   arb_state                 out  current state code for the Pi status reg
// -----------------------------------------------------------------------------
module bus_arbiter_ctrl
    import pistorm_pkg::*;
#(
    parameter int TIMEOUT_MC = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   mc_clk_rising,
    input  logic                   mc_clk_falling,
    input  logic                   acq_req,
    input  logic                   bg_n_sync,
    input  logic                   as_n_sync,
    input  logic                   dtack_n_sync,
    input  logic                   bgack_n_sync,
    input  logic                   reset_n_sync,
    input  logic                   eng_busy,
    output logic                   br_drive,
    output logic                   bgack_drive,
    output logic                   owned,
    output logic                   timeout,
    output logic [ARB_STATE_W-1:0] arb_state
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       br_drive_q;
    logic       br_drive_d;
    logic       bgack_drive_q;
    logic       bgack_drive_d;
    logic       owned_q;
    logic       owned_d;
    logic       timeout_q;
    logic       timeout_d;

    logic       cnt_clear_s;
    logic       cnt_en_s;
    logic       cnt_expired_s;
    logic       bus_quiet_s;
    logic       advance_s;
    arb_state_e advance_to_s;

    // No other master holds the bus and no cycle is in flight.
    assign bus_quiet_s = as_n_sync & dtack_n_sync & bgack_n_sync;

    arb_timeout_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_MC)
    ) u_timeout_cnt (
        .clk     (sys_clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_en_s),
        .expired (cnt_expired_s)
    );

    // Advance condition and target for the two waiting states.
    always_comb begin
        if (state_q == ARB_REQ) begin
            advance_s    = ~bg_n_sync;
            advance_to_s = ARB_WAIT_FREE;
        end else begin
            advance_s    = bus_quiet_s;
            advance_to_s = ARB_ACK;
        end
    end

    // Next-state logic; bus pins are decoded from the next state so that
    // every output changes on the same edge as the state it belongs to.
    always_comb begin
        state_d     = state_q;
        timeout_d   = 1'b0;
        cnt_clear_s = 1'b0;
        cnt_en_s    = 1'b0;
        if (!reset_n_sync) begin
            // 68k bus reset abandons everything, even an engine cycle.
            state_d = ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    cnt_clear_s = 1'b1;
                    if (acq_req && mc_clk_rising) begin
                        state_d = ARB_REQ;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
                ARB_REQ, ARB_WAIT_FREE: begin
                    if (!acq_req) begin
                        state_d = ARB_IDLE;
                    end else if (mc_clk_falling) begin
                        // An advancing edge beats a simultaneous timeout.
                        if (advance_s) begin
                            state_d = advance_to_s;
                        end else begin
                            cnt_en_s = 1'b1;
                            if (cnt_expired_s) begin
                                state_d   = ARB_HOLDOFF;
                                timeout_d = 1'b1;
                            end else begin
                                state_d = state_q;
                            end
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ARB_ACK: begin
                    // A dropped request is honoured only after OWN is reached.
                    if (mc_clk_rising) begin
                        state_d = ARB_OWN;
                    end else begin
                        state_d = ARB_ACK;
                    end
                end
                ARB_OWN: begin
                    if (!acq_req) begin
                        state_d = ARB_REL;
                    end else begin
                        state_d = ARB_OWN;
                    end
                end
                ARB_REL: begin
                    if (mc_clk_rising && !eng_busy) begin
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_REL;
                    end
                end
                ARB_HOLDOFF: begin
                    // No automatic retry: the Pi must withdraw the request.
                    if (!acq_req) begin
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_HOLDOFF;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
        br_drive_d    = arb_drives_br(state_d);
        bgack_drive_d = arb_drives_bgack(state_d);
        owned_d       = arb_is_owned(state_d);
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            br_drive_q    <= 1'b0;
            bgack_drive_q <= 1'b0;
            owned_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            br_drive_q    <= br_drive_d;
            bgack_drive_q <= bgack_drive_d;
            owned_q       <= owned_d;
            timeout_q     <= timeout_d;
        end
    end

    assign br_drive    = br_drive_q;
    assign bgack_drive = bgack_drive_q;
    assign owned       = owned_q;
    assign timeout     = timeout_q;
    assign arb_state   = state_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_ctrl
// Scoreboard bench: the stimulus process drives one cycle at a time, steps a
// behavioural model of the arbitration rules and queues the outputs expected
// after the next sys_clk edge; the monitor process compares them after the
// edge. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_ctrl;

    localparam int TO      = 8;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic       br;
        logic       bgack;
        logic       owned;
        logic       to;
        logic [2:0] st;
    } exp_t;

    logic       sys_clk;
    logic       reset;
    logic       mc_clk_rising;
    logic       mc_clk_falling;
    logic       acq_req;
    logic       bg_n_sync;
    logic       as_n_sync;
    logic       dtack_n_sync;
    logic       bgack_n_sync;
    logic       reset_n_sync;
    logic       eng_busy;
    logic       br_drive;
    logic       bgack_drive;
    logic       owned;
    logic       timeout;
    logic [2:0] arb_state;

    // Staged input values, applied by cyc() at the next falling sys_clk edge.
    bit s_reset = 1'b1, s_acq = 1'b0, s_bg = 1'b1, s_as = 1'b1, s_dt = 1'b1;
    bit s_bk = 1'b1, s_rn = 1'b1, s_busy = 1'b0;

    // 68k clock strobe generator state.
    int ph = 0;
    int half = 2;
    bit rand_half = 1'b0;

    // Model state: 0 idle,1 req,2 wait-free,3 ack,4 own,5 rel,6 holdoff.
    int m_st = 0;
    int m_cnt = 0;
    bit m_to = 1'b0;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    bus_arbiter_ctrl #(
        .TIMEOUT_MC (TO),
        .CNT_W      (CW)
    ) dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .mc_clk_rising  (mc_clk_rising),
        .mc_clk_falling (mc_clk_falling),
        .acq_req        (acq_req),
        .bg_n_sync      (bg_n_sync),
        .as_n_sync      (as_n_sync),
        .dtack_n_sync   (dtack_n_sync),
        .bgack_n_sync   (bgack_n_sync),
        .reset_n_sync   (reset_n_sync),
        .eng_busy       (eng_busy),
        .br_drive       (br_drive),
        .bgack_drive    (bgack_drive),
        .owned          (owned),
        .timeout        (timeout),
        .arb_state      (arb_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Arbitration rules applied to one sys_clk cycle of inputs.
    task automatic model_step(input bit rst, input bit rn, input bit rise,
                              input bit fall, input bit acq, input bit bg,
                              input bit as_q, input bit dt, input bit bk,
                              input bit busy);
        bit adv;
        m_to = 1'b0;
        if (rst) begin
            m_st  = 0;
            m_cnt = 0;
        end else if (!rn) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (rise && acq) begin
                m_st  = 1;
                m_cnt = 0;
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (!acq) begin
                m_st = 0;
            end else if (fall) begin
                adv = (m_st == 1) ? !bg : (as_q && dt && bk);
                if (adv) begin
                    m_st = m_st + 1;
                end else begin
                    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                    if (m_cnt >= TO) begin
                        m_st = 6;
                        m_to = 1'b1;
                    end
                end
            end
        end else if (m_st == 3) begin
            if (rise) m_st = 4;
        end else if (m_st == 4) begin
            if (!acq) m_st = 5;
        end else if (m_st == 5) begin
            if (rise && !busy) m_st = 0;
        end else begin
            if (!acq) m_st = 0;
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic cyc();
        exp_t e;
        bit   rise;
        bit   fall;
        @(negedge sys_clk);
        rise = (ph == 0);
        fall = (ph == half);
        ph = ph + 1;
        if (ph >= 2 * half) begin
            ph = 0;
            if (rand_half) half = $urandom_range(1, 4);
        end
        reset          = s_reset;
        mc_clk_rising  = rise;
        mc_clk_falling = fall;
        acq_req        = s_acq;
        bg_n_sync      = s_bg;
        as_n_sync      = s_as;
        dtack_n_sync   = s_dt;
        bgack_n_sync   = s_bk;
        reset_n_sync   = s_rn;
        eng_busy       = s_busy;
        model_step(s_reset, s_rn, rise, fall, s_acq, s_bg, s_as, s_dt, s_bk, s_busy);
        e.br    = (m_st >= 1 && m_st <= 3);
        e.bgack = (m_st >= 3 && m_st <= 5);
        e.owned = (m_st == 4);
        e.to    = m_to;
        e.st    = 3'(m_st);
        exp_q.push_back(e);
    endtask

    // Run until the model reaches a state, bounded.
    task automatic run_until(input int st, input int max_cyc);
        int n;
        n = 0;
        while (m_st != st && n < max_cyc) begin
            cyc();
            n = n + 1;
        end
    endtask

    // Monitor: compare DUT outputs with the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cycle_no = cycle_no + 1;
                checks = checks + 1;
                if (br_drive !== e.br || bgack_drive !== e.bgack || owned !== e.owned ||
                    timeout !== e.to || arb_state !== e.st) begin
                    errors = errors + 1;
                    $display("FAIL outputs cycle %0d: got br=%0b bgack=%0b owned=%0b timeout=%0b state=%0d, want br=%0b bgack=%0b owned=%0b timeout=%0b state=%0d",
                             cycle_no, br_drive, bgack_drive, owned, timeout, arb_state,
                             e.br, e.bgack, e.owned, e.to, e.st);
                end
            end
        end
    end

    // Absolute time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset = 1'b1; mc_clk_rising = 1'b0; mc_clk_falling = 1'b0; acq_req = 1'b0;
        bg_n_sync = 1'b1; as_n_sync = 1'b1; dtack_n_sync = 1'b1; bgack_n_sync = 1'b1;
        reset_n_sync = 1'b1; eng_busy = 1'b0;

        // Reset state, with a request pending to show reset priority.
        s_reset = 1'b1; s_acq = 1'b1; s_rn = 1'b0;
        repeat (4) cyc();
        s_acq = 1'b0; s_rn = 1'b1;
        repeat (2) cyc();
        s_reset = 1'b0;
        repeat (3) cyc();

        // Grant after a few falling edges on a quiet bus: REQ->WF->ACK->OWN.
        s_acq = 1'b1;
        repeat (14) cyc();
        s_bg = 1'b0;
        run_until(4, 20);
        repeat (3) cyc();

        // Release while the engine is busy for 5 cycles.
        s_busy = 1'b1; s_acq = 1'b0;
        repeat (5) cyc();
        s_busy = 1'b0;
        run_until(0, 20);
        s_bg = 1'b1;
        repeat (3) cyc();

        // Grant never comes: timeout after 8 falling edges, hold until release.
        s_acq = 1'b1;
        run_until(6, 80);
        repeat (6) cyc();
        s_acq = 1'b0;
        repeat (3) cyc();

        // Granted but address strobe busy for several edges.
        s_acq = 1'b1; s_bg = 1'b0; s_as = 1'b0;
        repeat (18) cyc();
        s_as = 1'b1;
        run_until(4, 20);
        s_acq = 1'b0;
        run_until(0, 20);
        repeat (2) cyc();

        // 68k bus reset while owned.
        s_acq = 1'b1;
        run_until(4, 30);
        s_rn = 1'b0; s_acq = 1'b0;
        cyc();
        s_rn = 1'b1;
        repeat (3) cyc();

        // Sync reset while waiting for a quiet bus.
        s_acq = 1'b1; s_as = 1'b0;
        run_until(2, 30);
        repeat (2) cyc();
        s_reset = 1'b1;
        cyc();
        s_reset = 1'b0; s_acq = 1'b0; s_as = 1'b1;
        repeat (3) cyc();

        // Request dropped on the same falling edge that brings the grant.
        s_bg = 1'b1; s_acq = 1'b1;
        run_until(1, 20);
        for (int i = 0; i < 10 && ph != half; i++) cyc();
        s_acq = 1'b0; s_bg = 1'b0;
        repeat (6) cyc();
        s_bg = 1'b1;

        // Request dropped during ACK.
        s_acq = 1'b1; s_bg = 1'b0;
        run_until(3, 30);
        s_acq = 1'b0;
        run_until(0, 30);
        repeat (2) cyc();

        // Randomized traffic with a varying 68k clock period.
        rand_half = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) s_acq = ~s_acq;
            if ($urandom_range(0, 3) == 0) s_bg = ~s_bg;
            s_as   = ($urandom_range(0, 3) != 0);
            s_dt   = ($urandom_range(0, 3) != 0);
            s_bk   = ($urandom_range(0, 5) != 0);
            s_busy = $urandom_range(0, 1) != 0;
            s_rn   = ($urandom_range(0, 79) != 0);
            s_reset = ($urandom_range(0, 299) == 0);
            cyc();
        end

        @(posedge sys_clk);
        #3;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
